// File: rtl/grid_ctrl_pkg.sv
// rtl/grid_ctrl_pkg.sv - shared types, dimensions and helpers for the Life board controller
package grid_ctrl_pkg;

  // Board dimensions shared by grid_state_ctrl and cell_grid
  localparam int DEFAULT_GRID_WIDTH  = 8;
  localparam int DEFAULT_GRID_HEIGHT = 8;
  localparam int DEFAULT_GEN_WIDTH   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DUMP = 2'd2
  } ctrl_state_e;

  // Row index needs at least one bit even for a single-row board
  function automatic int row_idx_width(input int height);
    return (height > 1) ? $clog2(height) : 1;
  endfunction

endpackage

// File: rtl/grid_state_ctrl.sv
// rtl/grid_state_ctrl.sv - board state owner with row-serial load and dump ports
module grid_state_ctrl
  import grid_ctrl_pkg::*;
#(
  parameter int GRID_WIDTH  = DEFAULT_GRID_WIDTH,
  parameter int GRID_HEIGHT = DEFAULT_GRID_HEIGHT,
  parameter int GEN_WIDTH   = DEFAULT_GEN_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load_valid,
  output logic                            load_ready,
  input  logic [GRID_WIDTH-1:0]           load_row,
  input  logic                            step,
  input  logic                            dump,
  input  logic [GRID_WIDTH*GRID_HEIGHT-1:0] next_state,
  output logic [GRID_WIDTH*GRID_HEIGHT-1:0] grid_state,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [GRID_WIDTH-1:0]           out_row,
  output logic                            out_last,
  output logic [GEN_WIDTH-1:0]            generation,
  output logic                            busy
);

  localparam int RW = row_idx_width(GRID_HEIGHT);
  localparam logic [RW-1:0] LAST_ROW = RW'(GRID_HEIGHT - 1);

  ctrl_state_e   state;
  logic [RW-1:0] row_idx;
  logic [RW-1:0] row_nxt;

  // Load port is open whenever no dump is in progress
  assign load_ready = (state == IDLE) || (state == LOAD);

  // Index of the row that follows the one currently presented or written
  always_comb begin
    row_nxt = row_idx + 1'b1;
  end

  // Control FSM with registered board, counter and dump outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      grid_state <= '0;
      generation <= '0;
      row_idx    <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_row    <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            grid_state[0 +: GRID_WIDTH] <= load_row;
            if (GRID_HEIGHT == 1) begin
              generation <= '0;
            end else begin
              row_idx <= RW'(1);
              state   <= LOAD;
              busy    <= 1'b1;
            end
          end else if (dump) begin
            row_idx   <= '0;
            state     <= DUMP;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_row   <= grid_state[0 +: GRID_WIDTH];
            out_last  <= (GRID_HEIGHT == 1);
          end else if (step) begin
            grid_state <= next_state;
            generation <= generation + 1'b1;
          end
        end
        LOAD: begin
          if (load_valid) begin
            grid_state[GRID_WIDTH*int'(row_idx) +: GRID_WIDTH] <= load_row;
            if (row_idx == LAST_ROW) begin
              row_idx    <= '0;
              generation <= '0;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              row_idx <= row_nxt;
            end
          end
        end
        DUMP: begin
          // out_valid is always high here, so out_ready alone completes a transfer
          if (out_ready) begin
            if (row_idx == LAST_ROW) begin
              row_idx   <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
              busy      <= 1'b0;
            end else begin
              row_idx  <= row_nxt;
              out_row  <= grid_state[GRID_WIDTH*int'(row_nxt) +: GRID_WIDTH];
              out_last <= (row_nxt == LAST_ROW);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grid_state_ctrl.sv
// tb/tb_grid_state_ctrl.sv - randomized self-checking bench for grid_state_ctrl
module tb_grid_state_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid, load_ready, step, dump, out_valid, out_ready, out_last, busy;
  logic [7:0]  load_row, out_row;
  logic [63:0] gs, ns;
  logic [15:0] gen;

  logic        w_step, w_load_ready, w_out_valid, w_out_last, w_busy;
  logic [7:0]  w_out_row;
  logic [63:0] w_gs, w_ns;
  logic [3:0]  w_gen;

  logic [63:0] mb;
  logic [15:0] mg;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  // Behavioural Game of Life with dead cells beyond the border
  function automatic logic [63:0] life(input logic [63:0] b);
    logic [63:0] n;
    int c;
    n = '0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        c = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (!(dy == 0 && dx == 0) && y+dy >= 0 && y+dy < 8 && x+dx >= 0 && x+dx < 8)
              c += int'(b[8*(y+dy)+x+dx]);
        n[8*y+x] = (c == 3) || (c == 2 && b[8*y+x]);
      end
    end
    return n;
  endfunction

  assign ns   = life(gs);
  assign w_ns = life(w_gs);

  grid_state_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_row(load_row), .step(step), .dump(dump), .next_state(ns), .grid_state(gs),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_last(out_last),
    .generation(gen), .busy(busy)
  );

  grid_state_ctrl #(.GEN_WIDTH(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .load_valid(1'b0), .load_ready(w_load_ready),
    .load_row(8'h00), .step(w_step), .dump(1'b0), .next_state(w_ns), .grid_state(w_gs),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_row(w_out_row), .out_last(w_out_last),
    .generation(w_gen), .busy(w_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_valid = 0; load_row = 0; step = 0; dump = 0; out_ready = 0; w_step = 0;
    tick(); tick();
    n_cmp++; if (gs !== 64'h0 || gen !== 16'h0) begin n_err++; $display("FAIL reset_state gs=%h gen=%0d want 0/0", gs, gen); end
    n_cmp++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_row !== 8'h0 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_outputs valid=%b last=%b row=%h busy=%b want all 0", out_valid, out_last, out_row, busy); end
    n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL reset_load_ready got %b want 1", load_ready); end
    rst_n = 1'b1;
    mb = '0; mg = '0;
  endtask

  // Row-serial load; with jitter, random idle cycles carry step/dump that must be dropped
  task automatic load_pattern(input logic [63:0] pat, input bit jitter);
    for (int i = 0; i < 8; i++) begin
      if (jitter && i > 0) begin
        while ($urandom_range(0, 2) == 0) begin
          load_valid = 0; step = 1'($urandom_range(0, 1)); dump = 1'($urandom_range(0, 1));
          tick();
        end
      end
      load_valid = 1; load_row = pat[8*i +: 8];
      n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL load_ready row %0d got %b want 1", i, load_ready); end
      tick();
    end
    load_valid = 0; step = 0; dump = 0;
    mb = pat; mg = '0;
    n_cmp++; if (gs !== mb || gen !== mg || busy !== 1'b0) begin
      n_err++; $display("FAIL load_done gs=%h gen=%0d busy=%b want %h/%0d/0", gs, gen, busy, mb, mg); end
  endtask

  task automatic step_n(input int n);
    step = 1;
    for (int i = 0; i < n; i++) begin
      tick();
      mb = life(mb); mg = mg + 16'd1;
      n_cmp++; if (gs !== mb || gen !== mg) begin
        n_err++; $display("FAIL step gs=%h gen=%0d want %h/%0d", gs, gen, mb, mg); end
    end
    step = 0;
  endtask

  // Dump and compare every presented row; stall_row holds out_ready low stall_cycles times
  task automatic dump_check(input int stall_row, input int stall_cycles, input bit rnd);
    int idx, budget, stalled;
    bit rdy;
    dump = 1; tick(); dump = 0;
    idx = 0; budget = 0; stalled = 0;
    while (idx < 8 && budget < 200) begin
      n_cmp++; if (out_valid !== 1'b1 || out_row !== mb[8*idx +: 8] || out_last !== (idx == 7)) begin
        n_err++; $display("FAIL dump_row %0d valid=%b row=%h last=%b want 1/%h/%b", idx, out_valid, out_row, out_last, mb[8*idx +: 8], idx == 7); end
      if (idx == stall_row && stalled < stall_cycles) begin rdy = 0; stalled++; end
      else if (rnd) rdy = 1'($urandom_range(0, 1));
      else rdy = 1;
      out_ready = rdy;
      step = 1'($urandom_range(0, 1));
      dump = 1'($urandom_range(0, 1));
      tick();
      if (rdy) idx++;
      budget++;
    end
    out_ready = 0; step = 0; dump = 0;
    n_cmp++; if (idx != 8) begin n_err++; $display("FAIL dump_timeout rows=%0d want 8", idx); end
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || gs !== mb || gen !== mg) begin
      n_err++; $display("FAIL dump_end valid=%b busy=%b gs=%h gen=%0d want 0/0/%h/%0d", out_valid, busy, gs, gen, mb, mg); end
  endtask

  task automatic test_round_trip();
    load_pattern(64'h8040_2010_0804_0201, 1'b0);
    dump_check(-1, 0, 1'b0);
    n_cmp++; if (gen !== 16'd0) begin n_err++; $display("FAIL round_trip_gen got %0d want 0", gen); end
  endtask

  task automatic test_blinker();
    load_pattern(64'h0000_0000_001C_0000, 1'b0);
    step_n(1);
    n_cmp++; if (gs !== 64'h0000_0000_0808_0800 || gen !== 16'd1) begin
      n_err++; $display("FAIL blinker_vertical gs=%h gen=%0d want 0000000008080800/1", gs, gen); end
    step_n(1);
    n_cmp++; if (gs !== 64'h0000_0000_001C_0000 || gen !== 16'd2) begin
      n_err++; $display("FAIL blinker_restore gs=%h gen=%0d want 00000000001c0000/2", gs, gen); end
  endtask

  task automatic test_backpressure();
    load_pattern(64'h8040_2010_0804_0201, 1'b0);
    dump_check(4, 3, 1'b0);
  endtask

  task automatic test_simultaneous();
    logic [63:0] pat;
    load_pattern(64'h0000_0000_001C_0000, 1'b0);
    step_n(1);
    pat = {$urandom, $urandom};
    load_valid = 1; load_row = pat[7:0]; dump = 1; step = 1;
    tick();
    n_cmp++; if (busy !== 1'b1 || out_valid !== 1'b0 || load_ready !== 1'b1) begin
      n_err++; $display("FAIL simul_state busy=%b valid=%b load_ready=%b want 1/0/1", busy, out_valid, load_ready); end
    n_cmp++; if (gs !== {mb[63:8], pat[7:0]} || gen !== mg) begin
      n_err++; $display("FAIL simul_no_step gs=%h gen=%0d want %h/%0d", gs, gen, {mb[63:8], pat[7:0]}, mg); end
    dump = 0;
    for (int i = 1; i < 8; i++) begin
      load_row = pat[8*i +: 8];
      tick();
    end
    load_valid = 0; step = 0;
    mb = pat; mg = '0;
    n_cmp++; if (gs !== mb || gen !== 16'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL simul_load gs=%h gen=%0d busy=%b want %h/0/0", gs, gen, busy, mb); end
    step_n(3);
    dump_check(-1, 0, 1'b1);
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 3; i++) begin
      load_valid = 1; load_row = 8'($urandom_range(1, 255)); tick();
    end
    load_valid = 0; rst_n = 0; tick(); rst_n = 1;
    mb = '0; mg = '0;
    n_cmp++; if (gs !== 64'h0 || gen !== 16'h0 || load_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_load gs=%h gen=%0d load_ready=%b busy=%b want 0/0/1/0", gs, gen, load_ready, busy); end
    load_pattern({$urandom, $urandom}, 1'b0);
  endtask

  task automatic test_gen_wrap();
    w_step = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      n_cmp++; if (w_gen !== 4'((i + 1) % 16) || w_gs !== 64'h0) begin
        n_err++; $display("FAIL gen_wrap step %0d gen=%0d gs=%h want %0d/0", i + 1, w_gen, w_gs, (i + 1) % 16); end
    end
    w_step = 0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      load_pattern({$urandom, $urandom}, 1'b1);
      step_n($urandom_range(1, 5));
      dump_check($urandom_range(0, 7), $urandom_range(0, 3), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_round_trip();
    test_blinker();
    test_backpressure();
    test_simultaneous();
    test_reset_mid_load();
    test_gen_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
